// File: rtl/prog_loader.sv
// prog_loader
//   Feeds a processor's instruction memory from a byte stream, then runs it.
//   Bytes arrive on a valid/ready/last stream and are packed big-endian into
//   32-bit words. Each word goes out as a single-cycle write to consecutive
//   word addresses. Once the word holding the final byte has been written,
//   `working` stays high for RUN_CYCLES cycles and is followed by a
//   single-cycle `done` pulse.
//
// Parameters
//   MEM_DEPTH   instruction-memory depth in words; writes at index >= MEM_DEPTH
//               are dropped and flagged through `overflow`
//   RUN_CYCLES  number of cycles `working` is held high per run (>= 1)
//
// Ports
//   clock       system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     program byte; the first byte of a word lands in wdata[31:24]
//   in_valid    in_data valid
//   in_last     final byte of the program; looked at only when a byte is accepted
//   in_ready    loader can accept a byte this cycle
//   addr        instruction-memory word address
//   wr          write strobe, one cycle per stored word
//   wdata       instruction word to write
//   working     processor run enable
//   done        single-cycle pulse at the end of the run window
//   overflow    sticky: at least one word was dropped in the current/last load
//   word_count  words actually written in the current/last load (saturates)

module prog_loader #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned RUN_CYCLES = 28
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] addr,
  output logic        wr,
  output logic [31:0] wdata,
  output logic        working,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] pack_q, pack_d;      // bytes already taken for the word in progress
  logic [1:0]  cnt_q, cnt_d;        // number of bytes held in pack_q
  logic [31:0] idx_q, idx_d;        // word index; never wraps at MEM_DEPTH
  logic        last_q, last_d;      // the word being written held the last byte
  logic [31:0] run_q, run_d;        // cycles already spent in RUN

  logic        in_ready_q, in_ready_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        working_q, working_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  wcnt_q, wcnt_d;

  // Starting values for the byte-accept path. In IDLE a new program begins, so
  // the per-load bookkeeping starts from zero. In LOAD it continues from the
  // registered values.
  logic        accept;
  logic [23:0] pack_base;
  logic [1:0]  cnt_base;
  logic [31:0] idx_base;
  logic [7:0]  wcnt_base;
  logic        ovf_base;
  logic [31:0] shifted;
  logic [2:0]  nbytes;
  logic [31:0] word;

  assign in_ready   = in_ready_q;
  assign addr       = addr_q;
  assign wr         = wr_q;
  assign wdata      = wdata_q;
  assign working    = working_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = wcnt_q;

  always_comb begin
    state_d    = state_q;
    pack_d     = pack_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    run_d      = run_q;
    in_ready_d = 1'b0;
    addr_d     = addr_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    working_d  = 1'b0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    wcnt_d     = wcnt_q;

    accept    = in_valid && in_ready_q;
    pack_base = pack_q;
    cnt_base  = cnt_q;
    idx_base  = idx_q;
    wcnt_base = wcnt_q;
    ovf_base  = ovf_q;
    shifted   = '0;
    nbytes    = '0;
    word      = '0;

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        in_ready_d = 1'b1;
        if (state_q == S_IDLE) begin
          pack_base = '0;
          cnt_base  = '0;
          idx_base  = '0;
          wcnt_base = '0;
          ovf_base  = 1'b0;
        end

        shifted = {pack_base, in_data};
        nbytes  = {1'b0, cnt_base} + 3'd1;
        // Left-align a partial word so the bytes received so far occupy the
        // top byte lanes and the unused lanes below them are zero.
        unique case (nbytes)
          3'd1:    word = {shifted[7:0], 24'h0};
          3'd2:    word = {shifted[15:0], 16'h0};
          3'd3:    word = {shifted[23:0], 8'h0};
          default: word = shifted;
        endcase

        if (accept) begin
          idx_d  = idx_base;
          wcnt_d = wcnt_base;
          ovf_d  = ovf_base;
          if (nbytes == 3'd4 || in_last) begin
            // The write outputs are registered on the edge that accepts the
            // byte completing the word, so they are already valid during the
            // WRITE cycle itself.
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
            last_d     = in_last;
            pack_d     = '0;
            cnt_d      = '0;
            idx_d      = idx_base + 32'd1;
            if (idx_base < MEM_DEPTH) begin
              wr_d    = 1'b1;
              addr_d  = idx_base;
              wdata_d = word;
              wcnt_d  = (wcnt_base == 8'hFF) ? 8'hFF : wcnt_base + 8'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            state_d = S_LOAD;
            pack_d  = shifted[23:0];
            cnt_d   = nbytes[1:0];
          end
        end
      end

      S_WRITE: begin
        if (last_q) begin
          state_d   = S_RUN;
          working_d = 1'b1;
          addr_d    = '0;
          run_d     = '0;
        end else begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
        end
      end

      S_RUN: begin
        addr_d = '0;
        run_d  = run_q + 32'd1;
        if (run_q == 32'(RUN_CYCLES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          working_d = 1'b1;
        end
      end

      S_DONE: begin
        addr_d     = '0;
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pack_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      run_q      <= '0;
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      working_q  <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      run_q      <= run_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      working_q  <= working_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wcnt_q     <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. It uses directed and randomised programs. A
// behavioural model, built from the byte list, supplies the expected words,
// the write addresses, the write timing and the run window.

module tb_prog_loader;

  localparam int unsigned MEM_DEPTH  = 16;
  localparam int unsigned RUN_CYCLES = 28;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic        done;
  logic        overflow;
  logic [7:0]  word_count;

  prog_loader #(
    .MEM_DEPTH (MEM_DEPTH),
    .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .addr      (addr),
    .wr        (wr),
    .wdata     (wdata),
    .working   (working),
    .done      (done),
    .overflow  (overflow),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  prog[$];
  int          acc_q[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_dq[$];
  int          wr_c[$];
  int          work_cnt, done_cnt, work_start, done_cyc, viol;
  logic        work_prev = 1'b0;

  // Sample the outputs 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (rst_n) begin
      if (wr) begin
        wr_a.push_back(addr);
        wr_dq.push_back(wdata);
        wr_c.push_back(cyc);
      end
      if (wr && in_ready) viol++;
      if (working) begin
        work_cnt++;
        if (!work_prev) work_start = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      work_prev = working;
    end else begin
      work_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4 * k + j < prog.size()) w[31 - 8 * j -: 8] = prog[4 * k + j];
    return w;
  endfunction

  task automatic clear_mon();
    wr_a.delete();
    wr_dq.delete();
    wr_c.delete();
    work_cnt   = 0;
    done_cnt   = 0;
    work_start = -1;
    done_cyc   = -1;
    viol       = 0;
  endtask

  // Called at a negedge. Presents one byte and returns the number of the
  // clock edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input logic l, output int acc_cyc);
    int g;
    g = 0;
    in_data  = b;
    in_last  = l;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (g >= 200) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "in_ready never asserted");
    end
    @(negedge clock);
    acc_cyc = cyc;
  endtask

  task automatic load_prog(input bit cont);
    int a;
    acc_q.delete();
    for (int i = 0; i < prog.size(); i++) begin
      send_byte(prog[i], (i == prog.size() - 1), a);
      acc_q.push_back(a);
      if (i == 0) chk("ovf_clear_on_start", 32'(overflow), 32'd0);
      if (!cont) begin
        // A gap cycle drives in_last high while in_valid is low. The loader
        // must ignore it.
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_program(input string name, input bit cont);
    int n, nw, nexp, g, li;
    n    = prog.size();
    nw   = (n + 3) / 4;
    nexp = (nw < int'(MEM_DEPTH)) ? nw : int'(MEM_DEPTH);
    clear_mon();
    load_prog(cont);
    g = 0;
    while (done_cnt == 0 && g < 400) begin
      @(negedge clock);
      g++;
    end
    chk({name, ":done_seen"}, 32'(done_cnt > 0), 32'd1);
    @(negedge clock);
    chk({name, ":wr_count"}, wr_a.size(), nexp);
    for (int k = 0; k < nexp && k < wr_a.size(); k++) begin
      li = (4 * k + 3 < n) ? 4 * k + 3 : n - 1;
      chk($sformatf("%s:wr_addr[%0d]", name, k), wr_a[k], k);
      chk($sformatf("%s:wr_data[%0d]", name, k), wr_dq[k], exp_word(k));
      chk($sformatf("%s:wr_cycle[%0d]", name, k), wr_c[k], acc_q[li]);
    end
    chk({name, ":work_cycles"}, work_cnt, RUN_CYCLES);
    chk({name, ":work_start"}, work_start, acc_q[n - 1] + 1);
    chk({name, ":done_cycle"}, done_cyc, acc_q[n - 1] + 1 + int'(RUN_CYCLES));
    chk({name, ":done_pulses"}, done_cnt, 1);
    chk({name, ":ready_in_write"}, viol, 0);
    chk({name, ":word_count"}, word_count, nexp);
    chk({name, ":overflow"}, 32'(overflow), 32'(nw > int'(MEM_DEPTH)));
    chk({name, ":idle_ready"}, 32'(in_ready), 32'd1);
    chk({name, ":idle_addr"}, addr, 32'd0);
    chk({name, ":idle_working"}, 32'(working), 32'd0);
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    int g, wc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;

    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst:in_ready", 32'(in_ready), 32'd0);
    chk("rst:addr", addr, 32'd0);
    chk("rst:wr", 32'(wr), 32'd0);
    chk("rst:wdata", wdata, 32'd0);
    chk("rst:working", 32'(working), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:overflow", 32'(overflow), 32'd0);
    chk("rst:word_count", word_count, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("rst:ready_after_release", 32'(in_ready), 32'd1);

    // Two full words, with idle gaps between bytes.
    prog = '{8'h10, 8'hF0, 8'h00, 8'h90, 8'h10, 8'hF1, 8'h00, 8'h91};
    run_program("two_words", 1'b0);
    if (wr_dq.size() > 1) begin
      chk("two_words:w0_const", wr_dq[0], 32'h10F00090);
      chk("two_words:w1_const", wr_dq[1], 32'h10F10091);
    end

    // Short program that produces one partial word.
    prog = '{8'h30, 8'h01};
    run_program("partial", 1'b0);
    if (wr_dq.size() > 0) chk("partial:w0_const", wr_dq[0], 32'h30010000);

    // 17 full words: the 17th word falls beyond the end of memory.
    rand_prog(68);
    run_program("overflow17", 1'b0);

    // in_valid held high for 8 bytes; the next load also clears overflow.
    rand_prog(8);
    run_program("continuous", 1'b1);

    // Asynchronous reset asserted in the middle of the run window.
    rand_prog(6);
    clear_mon();
    load_prog(1'b0);
    g = 0;
    while (working !== 1'b1 && g < 100) begin
      @(negedge clock);
      g++;
    end
    chk("midrst:reached_run", 32'(working), 32'd1);
    repeat (10) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:working_async", 32'(working), 32'd0);
    chk("midrst:addr_async", addr, 32'd0);
    chk("midrst:ready_async", 32'(in_ready), 32'd0);
    wc = work_cnt;
    chk("midrst:partial_window", 32'(wc < int'(RUN_CYCLES)), 32'd1);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (RUN_CYCLES + 5) @(negedge clock);
    chk("midrst:no_done", done_cnt, 0);
    chk("midrst:no_more_work", work_cnt, wc);
    rand_prog(5);
    run_program("after_midrst", 1'b0);

    // Random programs of mixed lengths and pacing.
    for (int r = 0; r < 4; r++) begin
      rand_prog($urandom_range(1, 40));
      run_program($sformatf("rand%0d", r), r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule
